lcd_fb_reader: RTL and testbench



---
 rtl/lcd_fb_reader.sv | 193 +++++++++++++++++++
 tb/tb_lcd_fb_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fb_reader.sv
// LCD raster reader for a 1-bit frame buffer: raster timing, RAM read address, RGB565 out.
// Outputs lag the raster counters by RD_LAT+1 clocks; no backpressure, runs at the pixel clock.
module lcd_fb_reader #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 3,
  parameter int unsigned V_BP       = 21,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned GRID_X     = 80,
  parameter int unsigned GRID_Y     = 48,
  parameter logic [15:0] FG_COLOR   = 16'hFFE0,
  parameter logic [15:0] GRID_COLOR = 16'h4208,
  parameter logic [15:0] BG_COLOR   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        grid_en,
  input  logic        q,
  output logic [18:0] rdaddress,
  output logic        rden,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        frame_done
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);
  localparam int unsigned XW = $clog2(GRID_X + 1);
  localparam int unsigned YW = $clog2(GRID_Y + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(GRID_X - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(GRID_Y - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  typedef struct packed {
    logic grid;
    logic vs;
    logic hs;
    logic de;
  } tim_t;

  localparam tim_t TIM_IDLE = tim_t'{grid: 1'b0, vs: 1'b1, hs: 1'b1, de: 1'b0};

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [XW-1:0] xm_q, xm_d;
  logic [YW-1:0] ym_q, ym_d;
  logic [18:0]   addr_q, addr_d;
  logic          rden_q, rden_d;
  logic          grid_frm_q, grid_frm_d;
  logic          frame_done_q, frame_done_d;
  tim_t          pipe_q [RD_LAT];
  tim_t          pipe_d [RD_LAT];
  tim_t          tim_raw, tim_out;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [15:0]   rgb_q, rgb_d;
  logic          scan, frame_end, frame_start;

  assign scan      = (state_q == SCAN);
  assign frame_end = scan && (h_q == H_LAST) && (v_q == V_LAST);

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    xm_d         = xm_q;
    ym_d         = ym_q;
    grid_frm_d   = grid_frm_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        h_d  = '0;
        v_d  = '0;
        xm_d = '0;
        ym_d = '0;
        if (run) begin
          state_d    = SCAN;
          grid_frm_d = grid_en;
        end
      end
      SCAN: begin
        if (h_q == H_LAST) begin
          h_d  = '0;
          xm_d = '0;
          if (v_q == V_LAST) begin
            v_d          = '0;
            ym_d         = '0;
            frame_done_d = 1'b1;
            grid_frm_d   = grid_en;
            if (!run) state_d = IDLE;
          end else begin
            v_d  = v_q + 1'b1;
            ym_d = (ym_q == Y_LAST) ? '0 : ym_q + 1'b1;
          end
        end else begin
          h_d  = h_q + 1'b1;
          xm_d = (xm_q == X_LAST) ? '0 : xm_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // rden/rdaddress are registered from the next-state counters so they line up with h_q/v_q
    frame_start = (state_d == SCAN) && ((state_q == IDLE) || frame_end);
    rden_d      = (state_d == SCAN) && (h_d < H_ACT) && (v_d < V_ACT);
    addr_d      = addr_q;
    if (frame_start) addr_d = '0;
    else if (rden_d) addr_d = addr_q + 19'd1;
  end

  always_comb begin
    tim_raw.de   = rden_q;
    tim_raw.hs   = !(scan && (h_q >= HS_FIRST) && (h_q <= HS_LAST));
    tim_raw.vs   = !(scan && (v_q >= VS_FIRST) && (v_q <= VS_LAST));
    tim_raw.grid = scan && grid_frm_q &&
                   ((xm_q == '0) || (ym_q == '0) || (h_q == H_ACT_LAST) || (v_q == V_ACT_LAST));
    pipe_d[0] = tim_raw;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

    tim_out = pipe_q[RD_LAT-1];
    hs_d    = tim_out.hs;
    vs_d    = tim_out.vs;
    de_d    = tim_out.de;
    if (!tim_out.de)      rgb_d = '0;
    else if (q)           rgb_d = FG_COLOR;
    else if (tim_out.grid) rgb_d = GRID_COLOR;
    else                  rgb_d = BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      h_q          <= '0;
      v_q          <= '0;
      xm_q         <= '0;
      ym_q         <= '0;
      addr_q       <= '0;
      rden_q       <= 1'b0;
      grid_frm_q   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= TIM_IDLE;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      de_q         <= 1'b0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      xm_q         <= xm_d;
      ym_q         <= ym_d;
      addr_q       <= addr_d;
      rden_q       <= rden_d;
      grid_frm_q   <= grid_frm_d;
      frame_done_q <= frame_done_d;
      pipe_q       <= pipe_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      de_q         <= de_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rdaddress  = addr_q;
  assign rden       = rden_q;
  assign lcd_hs     = hs_q;
  assign lcd_vs     = vs_q;
  assign lcd_de     = de_q;
  assign lcd_rgb    = rgb_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_fb_reader.sv
// Bench for lcd_fb_reader on a reduced raster: per-cycle reference model plus pixel table and corner sequences.
module tb_lcd_fb_reader;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 10, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int GX = 4, GY = 3;
  localparam int NPIX = HA * VA;
  localparam logic [15:0] FG = 16'hFFE0, GRIDC = 16'h4208, BG = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1, run = 1'b0, grid_en = 1'b0;
  logic q = 1'b0;
  logic [18:0] rdaddress;
  logic rden, lcd_hs, lcd_vs, lcd_de, frame_done;
  logic [15:0] lcd_rgb;

  lcd_fb_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .RD_LAT(2), .GRID_X(GX), .GRID_Y(GY)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .grid_en(grid_en), .q(q),
    .rdaddress(rdaddress), .rden(rden), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs),
    .lcd_de(lcd_de), .lcd_rgb(lcd_rgb), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Two-clock read latency RAM
  logic mem [NPIX];
  logic ram_s1 = 1'b0;
  always @(posedge clk) begin
    ram_s1 <= (rdaddress < 19'(NPIX)) ? mem[rdaddress] : 1'b0;
    q      <= ram_s1;
  end

  int n_checks = 0, n_fail = 0, cyc = 0;
  int cnt_de = 0, cnt_hs = 0, cnt_vs = 0;
  logic [15:0] cap [NPIX];
  int cap_idx = 0;

  // Reference model: frame position of the raster, plus a short history for the output lag
  bit m_scan = 0, m_grid = 0, m_fd = 0;
  int m_pos = 0, m_hold = 0;
  bit h_scan [4];
  int h_pos [4];
  bit h_grid [4];

  typedef struct {bit g; int x; int y; logic [15:0] rgb;} pix_t;
  pix_t tbl [17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_act(input int pos);
    return ((pos % HT) < HA) && ((pos / HT) < VA);
  endfunction

  function automatic int addr_of(input int pos);
    int h, v, cnt;
    h = pos % HT;
    v = pos / HT;
    if (v < VA) cnt = v * HA + ((h < HA) ? h + 1 : HA);
    else        cnt = NPIX;
    return cnt - 1;
  endfunction

  function automatic logic [15:0] pix(input int h, input int v, input bit g);
    if (mem[v * HA + h]) return FG;
    if (g && ((h % GX == 0) || (v % GY == 0) || (h == HA - 1) || (v == VA - 1))) return GRIDC;
    return BG;
  endfunction

  task automatic tick();
    bit r, n_scan, n_grid, n_fd, d3, e_hs, e_vs, e_rden;
    int n_pos, n_hold, h3, v3, e_addr;
    logic [15:0] e_rgb;
    logic [39:0] act, exp;
    r = rst; n_scan = m_scan; n_grid = m_grid; n_fd = 1'b0; n_pos = m_pos; n_hold = m_hold;
    if (r) begin
      n_scan = 0; n_pos = 0; n_grid = 0; n_hold = 0;
    end else if (!m_scan) begin
      if (run) begin n_scan = 1; n_pos = 0; n_grid = grid_en; end
    end else if (m_pos == FRAME - 1) begin
      n_fd = 1; n_hold = NPIX - 1; n_grid = grid_en; n_pos = 0; n_scan = run;
    end else begin
      n_pos = m_pos + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    m_scan = n_scan; m_pos = n_pos; m_grid = n_grid; m_fd = n_fd; m_hold = n_hold;
    for (int i = 3; i > 0; i--) begin
      h_scan[i] = r ? 1'b0 : h_scan[i-1];
      h_pos[i]  = h_pos[i-1];
      h_grid[i] = h_grid[i-1];
    end
    h_scan[0] = m_scan; h_pos[0] = m_pos; h_grid[0] = m_grid;

    if (lcd_de) cnt_de++;
    if (!lcd_hs) cnt_hs++;
    if (!lcd_vs) cnt_vs++;
    if (r) cap_idx = 0;
    else if (lcd_de) begin
      cap[cap_idx] = lcd_rgb;
      cap_idx = (cap_idx + 1) % NPIX;
    end

    d3 = 0; e_hs = 1; e_vs = 1; e_rgb = '0;
    if (h_scan[3]) begin
      h3 = h_pos[3] % HT;
      v3 = h_pos[3] / HT;
      d3 = (h3 < HA) && (v3 < VA);
      e_hs = !((h3 >= HA + HF) && (h3 < HA + HF + HS));
      e_vs = !((v3 >= VA + VF) && (v3 < VA + VF + VS));
      if (d3) e_rgb = pix(h3, v3, h_grid[3]);
    end
    e_rden = m_scan && is_act(m_pos);
    e_addr = m_scan ? addr_of(m_pos) : m_hold;
    exp = {e_rden, 19'(e_addr), e_hs, e_vs, d3, e_rgb, m_fd};
    act = {rden, rdaddress, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_done};
    chk("cycle", 64'(act), 64'(exp));
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    for (int i = 0; i < FRAME + 50; i++) begin
      tick();
      n++;
      if (frame_done) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL frame_done_timeout: no pulse within %0d clocks", FRAME + 50);
  endtask

  task automatic check_table(input bit g);
    for (int i = 0; i < 17; i++)
      if (tbl[i].g == g)
        chk($sformatf("pix_g%0d_x%0d_y%0d", g, tbl[i].x, tbl[i].y),
            64'(cap[tbl[i].y * HA + tbl[i].x]), 64'(tbl[i].rgb));
  endtask

  initial begin
    int lat, n, cyc_s;
    tbl[0]  = '{1, 0, 5, 16'hFFE0};  tbl[1]  = '{1, 1, 5, 16'h0000};
    tbl[2]  = '{1, 0, 4, 16'h4208};  tbl[3]  = '{1, 1, 4, 16'h0000};
    tbl[4]  = '{1, 1, 6, 16'h4208};  tbl[5]  = '{1, 4, 1, 16'h4208};
    tbl[6]  = '{1, 15, 1, 16'h4208}; tbl[7]  = '{1, 14, 1, 16'h0000};
    tbl[8]  = '{1, 14, 9, 16'h4208}; tbl[9]  = '{1, 5, 0, 16'h4208};
    tbl[10] = '{1, 13, 7, 16'h0000}; tbl[11] = '{1, 12, 8, 16'h4208};
    tbl[12] = '{1, 2, 2, 16'h0000};  tbl[13] = '{0, 0, 5, 16'hFFE0};
    tbl[14] = '{0, 0, 4, 16'h0000};  tbl[15] = '{0, 15, 9, 16'h0000};
    tbl[16] = '{0, 4, 3, 16'h0000};
    for (int i = 0; i < NPIX; i++) mem[i] = 1'b0;
    mem[5 * HA] = 1'b1;
    for (int i = 0; i < 4; i++) begin h_scan[i] = 0; h_pos[i] = 0; h_grid[i] = 0; end

    rst = 1;
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();
    chk("reset_out", 64'({lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_done, rden, rdaddress}),
        64'({1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 19'd0}));

    // Start: first read address next clock, display enable RD_LAT+1 later
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
    run = 1; grid_en = 1;
    tick();
    cyc_s = cyc;
    chk("first_rden", 64'(rden), 64'(1));
    chk("first_addr", 64'(rdaddress), 64'(0));
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (lcd_de) break;
    end
    chk("de_latency", 64'(lat), 64'(3));
    wait_fd(n);
    chk("frame_period", 64'(cyc - cyc_s), 64'(FRAME));
    chk("de_count", 64'(cnt_de), 64'(NPIX));
    chk("hs_low_count", 64'(cnt_hs), 64'(HS * VT));
    chk("vs_low_count", 64'(cnt_vs), 64'(VS * HT));
    check_table(1);

    // grid_en dropped mid-frame: this frame keeps the graticule, the next loses it
    repeat (150) tick();
    grid_en = 0;
    wait_fd(n);
    chk("frame2_len", 64'(150 + n), 64'(FRAME));
    check_table(1);
    wait_fd(n);
    check_table(0);

    // run dropped on line 4: the frame completes, then idle
    repeat (100) tick();
    run = 0;
    wait_fd(n);
    chk("drain_len", 64'(100 + n), 64'(FRAME));
    repeat (4) tick();
    chk("idle_out", 64'({lcd_hs, lcd_vs, lcd_de, lcd_rgb, rden}), 64'({1'b1, 1'b1, 1'b0, 16'h0, 1'b0}));
    chk("idle_addr_hold", 64'(rdaddress), 64'(NPIX - 1));
    for (int i = 0; i < NPIX; i++) mem[i] = ($urandom_range(0, 3) == 0);
    run = 1;
    tick();
    chk("restart_addr", 64'({rden, rdaddress}), 64'({1'b1, 19'd0}));

    // Reset mid-line at h=8, v=4
    repeat (4 * HT + 8) tick();
    rst = 1;
    tick();
    chk("midrst_out", 64'({lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_done, rden, rdaddress}),
        64'({1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 19'd0}));
    rst = 0;
    tick();
    chk("midrst_restart", 64'({rden, rdaddress}), 64'({1'b1, 19'd0}));

    // Random run/grid_en/rst activity against the model
    for (int c = 0; c < 3; c++) begin
      rst = 1;
      for (int i = 0; i < NPIX; i++) mem[i] = ($urandom_range(0, 7) == 0);
      repeat (2) tick();
      rst = 0;
      run = 1;
      grid_en = $urandom_range(0, 1);
      for (int i = 0; i < 900; i++) begin
        if ($urandom_range(0, 299) == 0) run = ~run;
        if ($urandom_range(0, 149) == 0) grid_en = ~grid_en;
        rst = ($urandom_range(0, 799) == 0);
        tick();
      end
      rst = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
